// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I widths, reset PC, NOP and opcode groups for fetch, decode and immediate generation
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam int INST_WIDTH = 32;
  localparam int PC_STEP = 4;
  localparam logic [INST_WIDTH-1:0] NOP = 32'h0000_0013;
  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_FENCE  = 7'b0001111,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;
  function automatic opcode_e opcode_of(input logic [INST_WIDTH-1:0] inst);
    return opcode_e'(inst[6:0]);
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: sync FIFO of {pc, inst}; push/pop/flush in, count/head out, flush overrides push and pop, rst_n sync active-low
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk)
    if (rst_n && !flush && push) mem[wr_ptr] <= din;
  assert property (@(posedge clk) disable iff (!rst_n) !(push && !flush && count == CW'(DEPTH)));
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner issuing imem_req_* word reads, queuing imem_resp_* with PCs, presenting inst_* to decode, flushing on redirect_*
module instruction_fetch_unit
  import rv32i_pkg::*;
#(
  parameter int XLEN = rv32i_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = rv32i_pkg::RESET_PC,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [XLEN-1:0]       imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_data,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst_data,
  output logic [XLEN-1:0]       inst_pc
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  logic [XLEN-1:0] fetch_pc, resp_pc, target;
  logic [CW-1:0] outstanding, drop_cnt, count;
  logic [XLEN+INST_WIDTH-1:0] head;
  logic req_fire, resp_keep;
  assign target = {redirect_pc[XLEN-1:2], 2'b00};
  assign imem_req_valid = rst_n && !redirect_valid &&
                          ({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(QUEUE_DEPTH);
  assign imem_req_addr = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign resp_keep = imem_resp_valid && drop_cnt == '0;
  assign inst_valid = count != '0;
  assign inst_data = inst_valid ? head[INST_WIDTH-1:0] : '0;
  assign inst_pc = inst_valid ? head[XLEN+INST_WIDTH-1:INST_WIDTH] : RESET_PC;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
      if (redirect_valid) begin
        fetch_pc <= target;
        resp_pc <= target;
        drop_cnt <= outstanding - CW'(imem_resp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        if (imem_resp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        if (resp_keep) resp_pc <= resp_pc + XLEN'(PC_STEP);
      end
    end
  end
  fetch_queue #(.WIDTH(XLEN + INST_WIDTH), .DEPTH(QUEUE_DEPTH)) u_queue (
    .clk  (clk),
    .rst_n(rst_n),
    .push (resp_keep && !redirect_valid),
    .pop  (inst_valid && inst_ready && !redirect_valid),
    .flush(redirect_valid),
    .din  ({resp_pc, imem_resp_data}),
    .count(count),
    .head (head)
  );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench with a latency-configurable memory model and directed fetch/redirect/reset scenarios
module tb_instruction_fetch_unit;
  logic clk = 0;
  logic rst_n = 0;
  logic imem_req_valid, imem_req_ready = 1;
  logic [31:0] imem_req_addr;
  logic imem_resp_valid = 0;
  logic [31:0] imem_resp_data = 0;
  logic redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic inst_valid, inst_ready = 0;
  logic [31:0] inst_data, inst_pc;
  typedef struct {logic [31:0] addr; int due;} pend_t;
  pend_t pend[$];
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  int total = 0, bad = 0, pops = 0, target = 0, acc = 0, cyc = 0, last_due = 0;
  int lat_min = 1, lat_max = 1, lat, d;
  bit mem_rnd = 0;
  instruction_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (pend.size() != 0 && pend[0].due == cyc) begin
      imem_resp_valid = 1;
      imem_resp_data = f(pend[0].addr);
      void'(pend.pop_front());
    end else imem_resp_valid = 0;
    imem_req_ready = mem_rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    @(negedge clk);
    if (!rst_n) begin
      pend.delete();
      last_due = 0;
    end else if (imem_req_valid && imem_req_ready) begin
      acc++;
      lat = $urandom_range(lat_min, lat_max);
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      pend.push_back('{addr: imem_req_addr, due: d});
      last_due = d;
    end
  end
  always @(negedge clk)
    if (rst_n && inst_valid && inst_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got pc %h expected none", inst_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("inst_pc", {32'h0, inst_pc}, {32'h0, mon_e[63:32]});
        chk("inst_data", {32'h0, inst_data}, {32'h0, mon_e[31:0]});
      end
    end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic run_stream(input logic [31:0] start, input int k, input bit rnd);
    logic [31:0] pc;
    int t = 0;
    for (int i = 0; i < k; i++) begin
      pc = start + 32'(4 * i);
      exp_q.push_back({pc, f(pc)});
    end
    target += k;
    while (pops < target && t < 3000) begin
      inst_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step(1);
      t++;
    end
    inst_ready = 0;
    chk("stream_done", 64'(pops), 64'(target));
    pops = target;
  endtask
  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1;
    redirect_pc = pc;
    step(1);
    redirect_valid = 0;
  endtask
  initial begin
    int t;
    step(2);
    @(negedge clk);
    chk("rst_req_valid", 64'(imem_req_valid), 0);
    chk("rst_inst_valid", 64'(inst_valid), 0);
    chk("rst_inst_data", 64'(inst_data), 0);
    chk("rst_inst_pc", 64'(inst_pc), 0);
    step(1);
    rst_n = 1;
    @(negedge clk);
    chk("first_req_valid", 64'(imem_req_valid), 1);
    chk("first_req_addr", 64'(imem_req_addr), 0);
    step(8);
    @(negedge clk);
    chk("bp_accepted", 64'(acc), 2);
    chk("bp_req_valid", 64'(imem_req_valid), 0);
    chk("bp_head_pc", 64'(inst_pc), 0);
    chk("bp_head_data", 64'(inst_data), 64'h0000_0000_DEAD_0000);
    step(1);
    run_stream(32'h0, 8, 0);
    step(8);
    @(negedge clk);
    chk("bp2_accepted", 64'(acc), 10);
    chk("bp2_req_valid", 64'(imem_req_valid), 0);
    step(1);
    run_stream(32'h20, 2, 0);
    lat_min = 3;
    lat_max = 3;
    redirect(32'h80);
    t = 0;
    while (pend.size() != 2 && t < 100) begin
      step(1);
      t++;
    end
    chk("inflight2", 64'(pend.size()), 2);
    redirect(32'h100);
    @(negedge clk);
    chk("rd1_inst_valid", 64'(inst_valid), 0);
    step(1);
    run_stream(32'h100, 4, 0);
    lat_min = 1;
    lat_max = 1;
    redirect(32'h40);
    t = 0;
    while (!imem_resp_valid && t < 100) begin
      step(1);
      t++;
    end
    chk("resp_seen", 64'(imem_resp_valid), 1);
    redirect(32'h203);
    @(negedge clk);
    chk("rd2_n1_inst_valid", 64'(inst_valid), 0);
    chk("rd2_n1_req_valid", 64'(imem_req_valid), 1);
    chk("rd2_n1_req_addr", 64'(imem_req_addr), 64'h200);
    @(negedge clk);
    chk("rd2_n2_inst_valid", 64'(inst_valid), 0);
    @(negedge clk);
    chk("rd2_n3_inst_valid", 64'(inst_valid), 1);
    chk("rd2_n3_inst_pc", 64'(inst_pc), 64'h200);
    chk("rd2_n3_inst_data", 64'(inst_data), 64'h0000_0000_DEAD_0200);
    step(1);
    run_stream(32'h200, 3, 0);
    redirect(32'hFFFF_FFF9);
    run_stream(32'hFFFF_FFF8, 4, 0);
    mem_rnd = 1;
    lat_min = 1;
    lat_max = 4;
    redirect(32'h1000);
    run_stream(32'h1000, 40, 1);
    mem_rnd = 0;
    lat_min = 1;
    lat_max = 1;
    redirect(32'h3000);
    step(4);
    @(negedge clk);
    chk("pre_rst_inst_valid", 64'(inst_valid), 1);
    step(1);
    rst_n = 0;
    step(1);
    rst_n = 1;
    @(negedge clk);
    chk("midrst_inst_valid", 64'(inst_valid), 0);
    chk("midrst_req_valid", 64'(imem_req_valid), 1);
    chk("midrst_req_addr", 64'(imem_req_addr), 0);
    step(1);
    run_stream(32'h0, 3, 0);
    chk("exp_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
